calc_sequencer: RTL and testbench

Operation sequencer for the calculator datapath. It sits between the operation selector (enter, sel, addSub, sgd) and the arithmetic units. On an operation request it latches the operands and mode. It then computes add/sub internally, or drives a start/done handshake to the external multiplier for mult/sqr. It registers the result with an overflow flag and pulses valid for the display path.

---
 rtl/calc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: operation sequencer for the calculator datapath.
// Latches operands on a rising edge of enter, computes add/sub locally or
// runs a start/done handshake with the external multiplier, then registers
// the result with an overflow flag and pulses valid for one cycle.
//
// Optional feature macro: MUL_TIMEOUT_EN (multiplier wait timeout with a
// sticky err flag). When undefined, the multiplier wait is unbounded and
// err is tied low.
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   enter               level request; a rising edge triggers an operation
//   sel                 00 unsigned add/sub, 01 signed add/sub, 10 mult, 11 sqr
//   addSub              0 add, 1 subtract (add/sub modes only)
//   sgd                 informational; sel[0] decides add/sub signedness
//   a, b                operands
//   mul_start           one-cycle start pulse to the multiplier
//   mul_a, mul_b        multiplier operands, held through the wait
//   mul_done, mul_p     multiplier completion strobe and product
//   result, ovf         registered result and overflow/borrow flag
//   busy                high outside IDLE
//   valid               one-cycle pulse when result/ovf update
//   err                 multiplier timeout flag
module calc_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enter,
  input  logic [1:0]         sel,
  input  logic               addSub,
  input  logic               sgd,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf,
  output logic               busy,
  output logic               valid,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL_REQ, MUL_WAIT, DONE} state_t;

  state_t             state, state_nx;
  logic               enter_q;
  logic               trig;
  logic               timeout_hit;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               signed_r;
  logic               sub_r;
  logic [WIDTH:0]     ea, eb, r;
  logic [2*WIDTH-1:0] as_res;
  logic               as_ovf;

  // sgd is informational only; TIMEOUT is unused in the default build.
  logic unused_ok;
  assign unused_ok = ^{sgd, TIMEOUT[0]};

  assign trig      = enter & ~enter_q;
  assign busy      = (state != IDLE);
  assign valid     = (state == DONE);
  assign mul_start = (state == MUL_REQ);

  // One (WIDTH+1)-bit adder covers all four add/sub modes: operands are
  // sign- or zero-extended by one bit, so r[WIDTH] is the carry/borrow in
  // unsigned mode and the exact sign bit in signed mode.
  always_comb begin
    ea     = {signed_r & a_r[WIDTH-1], a_r};
    eb     = {signed_r & b_r[WIDTH-1], b_r};
    r      = sub_r ? (ea - eb) : (ea + eb);
    as_res = '0;
    as_ovf = 1'b0;
    if (signed_r) begin
      as_res = {{(WIDTH-1){r[WIDTH]}}, r};
      as_ovf = r[WIDTH] ^ r[WIDTH-1];
    end else if (sub_r) begin
      as_res = {{WIDTH{1'b0}}, r[WIDTH-1:0]};
      as_ovf = r[WIDTH];
    end else begin
      as_res = {{(WIDTH-1){1'b0}}, r};
      as_ovf = r[WIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (trig) state_nx = sel[1] ? MUL_REQ : ADDSUB;
      ADDSUB:   state_nx = DONE;
      MUL_REQ:  state_nx = MUL_WAIT;
      MUL_WAIT: if (mul_done || timeout_hit) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      enter_q  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      sub_r    <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      state   <= state_nx;
      enter_q <= enter;
      case (state)
        IDLE: begin
          if (trig) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= sel[0];
            sub_r    <= addSub;
            if (sel[1]) begin
              mul_a <= a;
              mul_b <= sel[0] ? a : b;
            end
          end
        end
        ADDSUB: begin
          result <= as_res;
          ovf    <= as_ovf;
        end
        MUL_WAIT: begin
          if (mul_done) begin
            result <= mul_p;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // A simultaneous mul_done takes priority over expiry.
  assign timeout_hit = (state == MUL_WAIT) && !mul_done &&
                       (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && trig) err <= 1'b0;
      else if (timeout_hit)      err <= 1'b1;
      if (state == MUL_REQ)       cnt <= '0;
      else if (state == MUL_WAIT) cnt <= cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n, enter, addSub, sgd, mul_done;
  logic [1:0]     sel;
  logic [W-1:0]   a, b, mul_a, mul_b;
  logic [2*W-1:0] mul_p, result;
  logic           mul_start, ovf, busy, valid, err;

  calc_sequencer #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .enter(enter), .sel(sel), .addSub(addSub),
    .sgd(sgd), .a(a), .b(b), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_p(mul_p), .result(result),
    .ovf(ovf), .busy(busy), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           ovf;
  } exp_t;

  exp_t           sbq[$];
  int             vectors = 0;
  int             miscompares = 0;
  int             start_cnt = 0;
  int             valid_cnt = 0;
  logic [2*W-1:0] last_res = '0;
  logic           last_ovf = 1'b0;

  // Scoreboard consumer: every valid pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (mul_start === 1'b1) start_cnt++;
      if (valid === 1'b1) begin
        valid_cnt++;
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: result=%h ovf=%b, no result expected", result, ovf);
        end else begin
          e = sbq.pop_front();
          if (result !== e.res || ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL result: got %h ovf=%b, expected %h ovf=%b", result, ovf, e.res, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2*W-1:0] res, input logic o);
    exp_t e;
    e.res = res;
    e.ovf = o;
    sbq.push_back(e);
    last_res = res;
    last_ovf = o;
  endtask

  task automatic do_addsub(input logic [1:0] s, input logic sub, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [2*W-1:0] er, input logic eo);
    sel = s; addSub = sub; a = x; b = y; sgd = s[0]; enter = 1'b1;
    push(er, eo);
    step(1);
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL as_compute: busy=%b valid=%b, expected busy=1 valid=0", busy, valid);
    end
    step(1);
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL as_latency: busy=%b valid=%b, expected busy=1 valid=1", busy, valid);
    end
    step(1);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL as_idle: busy=%b valid=%b, expected 0 0", busy, valid);
    end
    enter = 1'b0;
    step(1);
  endtask

  // Multiplier model: product supplied by the caller, done strobe driven
  // d cycles after the start pulse; 'early' also pulses done alongside start.
  task automatic do_mul(input logic [1:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int d, input logic [2*W-1:0] p, input bit early);
    int st0, v0;
    logic [W-1:0] eb;
    eb  = s[0] ? x : y;
    st0 = start_cnt;
    v0  = valid_cnt;
    sel = s; a = x; b = y; addSub = 1'b0; enter = 1'b1;
    push(p, 1'b0);
    step(1);
    vectors++;
    if (mul_start !== 1'b1 || mul_a !== x || mul_b !== eb) begin
      miscompares++;
      $display("FAIL mul_req: start=%b mul_a=%h mul_b=%h, expected 1 %h %h", mul_start, mul_a, mul_b, x, eb);
    end
    if (early) begin
      mul_done = 1'b1;
      mul_p = 16'hDEAD;
    end
    for (int i = 1; i < d; i++) begin
      step(1);
      mul_done = 1'b0;
      enter = 1'b0;
      vectors++;
      if (busy !== 1'b1 || valid !== 1'b0 || mul_start !== 1'b0 || mul_a !== x || mul_b !== eb) begin
        miscompares++;
        $display("FAIL mul_wait: busy=%b valid=%b start=%b mul_a=%h mul_b=%h", busy, valid, mul_start, mul_a, mul_b);
      end
    end
    step(1);
    mul_done = 1'b1;
    mul_p = p;
    step(1);
    mul_done = 1'b0;
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_latency: valid=%b, expected 1", valid);
    end
    step(1);
    vectors++;
    if (start_cnt - st0 != 1 || valid_cnt - v0 != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_pulses: starts=%0d valids=%0d busy=%b, expected 1 1 0", start_cnt - st0, valid_cnt - v0, busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enter = 1'b0; sel = '0; addSub = 1'b0; sgd = 1'b0;
    a = '0; b = '0; mul_done = 1'b0; mul_p = '0;
    step(2);
    vectors++;
    if ({result, ovf, valid, busy, mul_start, mul_a, mul_b, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: result=%h ovf=%b valid=%b busy=%b start=%b mul_a=%h mul_b=%h err=%b, expected all 0",
               result, ovf, valid, busy, mul_start, mul_a, mul_b, err);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_addsub;
    do_addsub(2'b00, 1'b0, 8'd200, 8'd100, 16'h012C, 1'b1);
    do_addsub(2'b00, 1'b0, 8'd1,   8'd2,   16'h0003, 1'b0);
    do_addsub(2'b00, 1'b1, 8'd5,   8'd7,   16'h00FE, 1'b1);
    do_addsub(2'b00, 1'b1, 8'd9,   8'd4,   16'h0005, 1'b0);
  endtask

  task automatic test_signed;
    do_addsub(2'b01, 1'b1, 8'h80, 8'h01, 16'hFF7F, 1'b1);
    do_addsub(2'b01, 1'b1, 8'h05, 8'h07, 16'hFFFE, 1'b0);
    do_addsub(2'b01, 1'b0, 8'h7F, 8'h01, 16'h0080, 1'b1);
    do_addsub(2'b01, 1'b0, 8'hFF, 8'hFF, 16'hFFFE, 1'b0);
  endtask

  task automatic test_mul;
    do_mul(2'b11, 8'd12, 8'd99, 5, 16'd144, 1'b0);
    do_mul(2'b10, 8'd255, 8'd255, 2, 16'hFE01, 1'b0);
  endtask

  task automatic test_early_done;
    do_mul(2'b10, 8'd7, 8'd9, 3, 16'd63, 1'b1);
  endtask

  task automatic test_held_enter;
    int st0, v0;
    st0 = start_cnt;
    v0  = valid_cnt;
    sel = 2'b10; a = 8'd3; b = 8'd4; enter = 1'b1;
    push(16'd12, 1'b0);
    step(3);
    enter = 1'b0;
    step(1);
    enter = 1'b1;
    step(2);
    mul_done = 1'b1; mul_p = 16'd12;
    step(1);
    mul_done = 1'b0;
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL held_latency: valid=%b, expected 1", valid);
    end
    step(6);
    vectors++;
    if (start_cnt - st0 != 1 || valid_cnt - v0 != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL held_enter: starts=%0d valids=%0d busy=%b, expected 1 1 0", start_cnt - st0, valid_cnt - v0, busy);
    end
    enter = 1'b0;
    step(1);
  endtask

  task automatic test_timeout;
    bit ok;
    sel = 2'b10; a = 8'd9; b = 8'd9; enter = 1'b1;
`ifdef MUL_TIMEOUT_EN
    push(last_res, last_ovf);
    step(1);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      enter = 1'b0;
      if (busy !== 1'b1 || valid !== 1'b0 || err !== 1'b0) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL timeout_wait: busy/valid/err wrong during 16 wait cycles");
    end
    step(1);
    vectors++;
    if (valid !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_expire: valid=%b err=%b, expected 1 1", valid, err);
    end
    step(1);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sticky: err=%b busy=%b, expected 1 0", err, busy);
    end
    sel = 2'b00; addSub = 1'b0; a = 8'd1; b = 8'd2; enter = 1'b1;
    push(16'h0003, 1'b0);
    step(1);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: err=%b, expected 0", err);
    end
    step(2);
    enter = 1'b0;
    step(2);
`else
    step(1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      enter = 1'b0;
      if (busy !== 1'b1 || valid !== 1'b0 || err !== 1'b0) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_forever: busy/valid/err wrong during unbounded wait");
    end
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    last_res = '0;
    last_ovf = 1'b0;
    step(1);
`endif
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = valid_cnt;
    sel = 2'b10; a = 8'd5; b = 8'd6; enter = 1'b1;
    step(3);
    reset_n = 1'b0;
    enter = 1'b0;
    #1;
    vectors++;
    if ({result, ovf, valid, busy, mul_start, mul_a, mul_b, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: result=%h ovf=%b valid=%b busy=%b start=%b mul_a=%h mul_b=%h err=%b, expected all 0",
               result, ovf, valid, busy, mul_start, mul_a, mul_b, err);
    end
    step(1);
    reset_n = 1'b1;
    last_res = '0;
    last_ovf = 1'b0;
    step(1);
    mul_done = 1'b1; mul_p = 16'd30;
    step(1);
    mul_done = 1'b0;
    step(3);
    vectors++;
    if (valid_cnt != v0 || result !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL late_done: valids=%0d result=%h busy=%b, expected 0 0000 0", valid_cnt - v0, result, busy);
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_signed();
    test_mul();
    test_early_done();
    test_held_enter();
    test_timeout();
    test_reset_mid();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results still pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
